mux_n1_stream: RTL and testbench
================================

# mux_n1_stream

Registered N-to-1 stream multiplexer with valid/ready handshakes on every input and on the output. It selects one of N W-bit input channels per cycle by round-robin arbitration and captures the winning word in a single output register. It sits where the datapath merges several producer streams onto one consumer, and it replaces the combinational 2:1 select wherever back-pressure and fairness are needed.

## Interface

Parameters:
- W, 8: data width per channel, ≥1.
- N, 2: number of input channels, 2..16.
- SW, 1: select/channel-id width; 2^SW ≥ N is required.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- i  input  N*W  input data; channel k is i[k*W +: W].
- i_vld  input  N  per-channel valid.
- i_rdy  output  N  per-channel ready; a transfer on channel k happens when i_vld[k] & i_rdy[k].
- o  output  W  output data.
- o_ch  output  SW  channel index that produced o.
- o_vld  output  1  output valid.
- o_rdy  input  1  output ready from the consumer.
- s  input  SW  forced channel select; present only with MUX_N1_SEL_EN.
- s_en  input  1  select override enable; present only with MUX_N1_SEL_EN.

## Operation

- State:
  - Output register (o, o_ch, o_vld).
  - Round-robin pointer p (SW bits), the highest-priority channel.
- load = ~o_vld | o_rdy: the register is empty, or is being drained this cycle.
- Arbitration, combinational:
  - Scan channels p, p+1, …, N-1, 0, …, p-1.
  - Grant g is the first channel with i_vld set.
  - If no channel is valid, there is no grant.
- i_rdy[k] = load & grant valid & (g == k). At most one bit of i_rdy is high in any cycle. i_rdy depends combinationally on i_vld and o_rdy.
- On a transfer from channel g:
  - o ← i[g], o_ch ← g, o_vld ← 1.
  - p ← g+1, wrapping N-1 → 0.
- Drain with no grant (load high, no channel valid): o_vld ← 0; o and o_ch keep their last values.
- Hold (o_vld=1, o_rdy=0): o, o_ch and o_vld are held stable. All i_rdy are 0. p is unchanged.
- Simultaneous drain and accept in the same cycle is required: a full-throughput stream gives one word per cycle.
- p changes only on a transfer.
- Reset values: o=0, o_ch=0, o_vld=0, p=0. Reset takes priority over any transfer in the same cycle.
- Reset mid-operation: a held word is discarded and no input transfer completes in the reset cycle, because i_rdy is forced to 0 while rst=1.

## Timing

- Latency: a word accepted at edge t appears on o/o_vld after edge t (one cycle).
- Throughput: 1 word/cycle aggregate.
- Fairness: with all N channels continuously valid and o_rdy=1, each channel is granted exactly once in every N consecutive transfers.
- Worst-case wait for a valid channel: N-1 transfers, provided o_rdy keeps draining.
- Combinational paths:
  - i_vld → i_rdy.
  - o_rdy → i_rdy.
  - No combinational path from inputs to o, o_ch or o_vld.

## Configuration

- MUX_N1_SEL_EN defined:
  - Ports s and s_en exist.
  - While s_en=1, only channel s is eligible; g=s if i_vld[s], otherwise there is no grant.
  - s ≥ N yields no grant.
  - p is not updated by override transfers.
  - While s_en=0, behaviour is pure round-robin.
- MUX_N1_SEL_EN not defined:
  - s and s_en are absent.
  - Arbitration is always round-robin.

## Test plan

- Reset: assert rst for 2 cycles with all i_vld=1 → o_vld=0, o=0, o_ch=0, i_rdy=0 during reset. The first grant after reset goes to channel 0.
- N=4, W=8, i=0x44,0x33,0x22,0x11 (ch3..0), all valid, o_rdy=1 → o_ch sequence 0,1,2,3,0,…; o_vld high every cycle from 1 cycle after reset release.
- Back-pressure: ch1 valid with 0xA5, o_rdy=0 for 5 cycles → o=0xA5 and o_ch=1 stable, all i_rdy=0. After o_rdy=1, the next word is accepted in that same cycle.
- Drain to empty: one word from ch2, then all i_vld=0, o_rdy=1 → o_vld high 1 cycle, then 0; o keeps the last value.
- Mid-operation reset: o_vld=1 holding 0x5A, pulse rst one cycle → o_vld=0 next cycle, no i_rdy asserted during reset, p returns to 0.
- With MUX_N1_SEL_EN, s_en=1, s=3, all channels valid → only ch3 is granted every cycle. After s_en=0, round-robin resumes from the pointer value held before the override.

Source files
------------

// File: rtl/mux_n1_stream.sv
// Registered N-to-1 stream mux with round-robin arbitration and valid/ready on every port.
// Optional forced-select override (ports s, s_en) is enabled by defining MUX_N1_SEL_EN.
module mux_n1_stream #(
  parameter int W  = 8,
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  i,
  input  logic [N-1:0]    i_vld,
  output logic [N-1:0]    i_rdy,
  output logic [W-1:0]    o,
  output logic [SW-1:0]   o_ch,
  output logic            o_vld,
  input  logic            o_rdy
`ifdef MUX_N1_SEL_EN
  ,
  input  logic [SW-1:0]   s,
  input  logic            s_en
`endif
);

  logic [W-1:0]  o_q, o_d;
  logic [SW-1:0] o_ch_q, o_ch_d;
  logic          o_vld_q, o_vld_d;
  logic [SW-1:0] p_q, p_d;

  logic          load;
  logic          gnt_vld;
  logic          ovr;
  logic [SW-1:0] gnt;
  logic          xfer;

  // First valid channel at or after the pointer, wrapping at N.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    ovr     = 1'b0;
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = int'(p_q) + off;
      if (idx >= N) idx = idx - N;
      if (!gnt_vld && i_vld[idx]) begin
        gnt     = SW'(idx);
        gnt_vld = 1'b1;
      end
    end
`ifdef MUX_N1_SEL_EN
    if (s_en) begin
      ovr     = 1'b1;
      gnt     = s;
      gnt_vld = (int'(s) < N) ? i_vld[s] : 1'b0;
    end
`endif
  end

  assign load  = ~o_vld_q | o_rdy;
  assign xfer  = gnt_vld & load & ~rst;
  assign i_rdy = xfer ? (N'(1) << gnt) : '0;

  always_comb begin
    o_d     = o_q;
    o_ch_d  = o_ch_q;
    o_vld_d = o_vld_q;
    p_d     = p_q;
    if (xfer) begin
      o_d     = i[int'(gnt)*W +: W];
      o_ch_d  = gnt;
      o_vld_d = 1'b1;
      // Override transfers leave the round-robin position untouched.
      if (!ovr) p_d = (int'(gnt) == N-1) ? '0 : gnt + SW'(1);
    end else if (load) begin
      o_vld_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q     <= '0;
      o_ch_q  <= '0;
      o_vld_q <= 1'b0;
      p_q     <= '0;
    end else begin
      o_q     <= o_d;
      o_ch_q  <= o_ch_d;
      o_vld_q <= o_vld_d;
      p_q     <= p_d;
    end
  end

  assign o     = o_q;
  assign o_ch  = o_ch_q;
  assign o_vld = o_vld_q;

endmodule

// File: tb/tb_mux_n1_stream.sv
// Self-checking bench for mux_n1_stream (N=4, W=8): directed scenarios plus a randomized run
// against a behavioural model of the arbitration rules.
module tb_mux_n1_stream;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] i = '0;
  logic [N-1:0]   i_vld = '0;
  logic [N-1:0]   i_rdy;
  logic [W-1:0]   o;
  logic [SW-1:0]  o_ch;
  logic           o_vld;
  logic           o_rdy = 1'b0;
`ifdef MUX_N1_SEL_EN
  logic [SW-1:0]  s = '0;
  logic           s_en = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Model state
  logic [W-1:0] m_o;
  int           m_ch;
  logic         m_vld;
  int           m_p;

  always #5 clk = ~clk;

  mux_n1_stream #(.W(W), .N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .i     (i),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .o     (o),
    .o_ch  (o_ch),
    .o_vld (o_vld),
    .o_rdy (o_rdy)
`ifdef MUX_N1_SEL_EN
    ,
    .s     (s),
    .s_en  (s_en)
`endif
  );

  function automatic bit ref_override();
`ifdef MUX_N1_SEL_EN
    return s_en;
`else
    return 1'b0;
`endif
  endfunction

  // Channel that transfers this cycle, or -1.
  function automatic int ref_grant();
    if (rst) return -1;
    if (m_vld && !o_rdy) return -1;
`ifdef MUX_N1_SEL_EN
    if (s_en) return (int'(s) < N && i_vld[s]) ? int'(s) : -1;
`endif
    for (int k = 0; k < N; k++) begin
      if (i_vld[(m_p + k) % N]) return (m_p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] ref_rdy();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = ref_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic apply(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic r);
    i = d;
    i_vld = v;
    o_rdy = r;
    #1;
  endtask

  // Advance one clock and update the model with the inputs seen before the edge.
  task automatic tick();
    int g;
    bit ov;
    logic [W-1:0] word;
    g = ref_grant();
    ov = ref_override();
    word = (g >= 0) ? i[g*W +: W] : '0;
    @(posedge clk);
    if (rst) begin
      m_o = '0; m_ch = 0; m_vld = 1'b0; m_p = 0;
    end else if (g >= 0) begin
      m_o = word; m_ch = g; m_vld = 1'b1;
      if (!ov) m_p = (g + 1) % N;
    end else if (!m_vld || o_rdy) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
`ifdef MUX_N1_SEL_EN
    s_en = 1'b0;
`endif
    apply('0, '0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      apply(32'h44332211, 4'hF, 1'b1);
      checks++;
      if (i_rdy !== 4'h0) begin failures++; $display("FAIL reset_rdy got=%h exp=0", i_rdy); end
      tick();
      checks++;
      if (o_vld !== 1'b0 || o !== 8'h00 || o_ch !== 2'd0) begin
        failures++; $display("FAIL reset_state got vld=%b o=%h ch=%0d exp vld=0 o=00 ch=0", o_vld, o, o_ch);
      end
    end
    rst = 1'b0;
    apply(32'h44332211, 4'hF, 1'b1);
    checks++;
    if (i_rdy !== 4'b0001) begin failures++; $display("FAIL reset_first_rdy got=%b exp=0001", i_rdy); end
    tick();
    checks++;
    if (o_ch !== 2'd0 || o_vld !== 1'b1 || o !== 8'h11) begin
      failures++; $display("FAIL reset_first_grant got ch=%0d vld=%b o=%h exp ch=0 vld=1 o=11", o_ch, o_vld, o);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_o;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      apply(32'h44332211, 4'hF, 1'b1);
      tick();
      exp_o = 8'h11 * 8'((k % 4) + 1);
      checks++;
      if (o_ch !== 2'(k % 4) || o !== exp_o || o_vld !== 1'b1) begin
        failures++;
        $display("FAIL round_robin[%0d] got ch=%0d o=%h vld=%b exp ch=%0d o=%h vld=1", k, o_ch, o, o_vld, k % 4, exp_o);
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    apply(32'h0000A500, 4'b0010, 1'b1);
    tick();
    for (int c = 0; c < 5; c++) begin
      apply(32'h0000A500, 4'b0010, 1'b0);
      checks++;
      if (i_rdy !== 4'h0) begin failures++; $display("FAIL bp_rdy[%0d] got=%b exp=0000", c, i_rdy); end
      tick();
      checks++;
      if (o !== 8'hA5 || o_ch !== 2'd1 || o_vld !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d] got o=%h ch=%0d vld=%b exp o=a5 ch=1 vld=1", c, o, o_ch, o_vld);
      end
    end
    apply(32'h00005C00, 4'b0010, 1'b1);
    checks++;
    if (i_rdy !== 4'b0010) begin failures++; $display("FAIL bp_release_rdy got=%b exp=0010", i_rdy); end
    tick();
    checks++;
    if (o !== 8'h5C || o_ch !== 2'd1 || o_vld !== 1'b1) begin
      failures++; $display("FAIL bp_release got o=%h ch=%0d vld=%b exp o=5c ch=1 vld=1", o, o_ch, o_vld);
    end
  endtask

  task automatic test_drain();
    do_reset();
    apply(32'h00330000, 4'b0100, 1'b1);
    tick();
    checks++;
    if (o_vld !== 1'b1 || o !== 8'h33 || o_ch !== 2'd2) begin
      failures++; $display("FAIL drain_word got vld=%b o=%h ch=%0d exp vld=1 o=33 ch=2", o_vld, o, o_ch);
    end
    for (int c = 0; c < 2; c++) begin
      apply(32'h00330000, 4'b0000, 1'b1);
      tick();
      checks++;
      if (o_vld !== 1'b0 || o !== 8'h33 || o_ch !== 2'd2) begin
        failures++; $display("FAIL drain_empty[%0d] got vld=%b o=%h ch=%0d exp vld=0 o=33 ch=2", c, o_vld, o, o_ch);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    apply(32'h005A0000, 4'b0100, 1'b1);
    tick();
    checks++;
    if (o !== 8'h5A || o_vld !== 1'b1) begin failures++; $display("FAIL mid_load got o=%h vld=%b exp o=5a vld=1", o, o_vld); end
    rst = 1'b1;
    apply(32'h44332211, 4'hF, 1'b1);
    checks++;
    if (i_rdy !== 4'h0) begin failures++; $display("FAIL mid_rst_rdy got=%b exp=0000", i_rdy); end
    tick();
    rst = 1'b0;
    checks++;
    if (o_vld !== 1'b0) begin failures++; $display("FAIL mid_rst_vld got=%b exp=0", o_vld); end
    apply(32'h44332211, 4'hF, 1'b1);
    checks++;
    if (i_rdy !== 4'b0001) begin failures++; $display("FAIL mid_rst_ptr got=%b exp=0001", i_rdy); end
    tick();
    checks++;
    if (o_ch !== 2'd0 || o !== 8'h11) begin failures++; $display("FAIL mid_rst_grant got ch=%0d o=%h exp ch=0 o=11", o_ch, o); end
  endtask

`ifdef MUX_N1_SEL_EN
  task automatic test_override();
    do_reset();
    apply(32'h44332211, 4'hF, 1'b1);
    tick();
    s = 2'd3;
    s_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      apply(32'h44332211, 4'hF, 1'b1);
      checks++;
      if (i_rdy !== 4'b1000) begin failures++; $display("FAIL ovr_rdy[%0d] got=%b exp=1000", c, i_rdy); end
      tick();
      checks++;
      if (o_ch !== 2'd3 || o !== 8'h44) begin failures++; $display("FAIL ovr_ch[%0d] got ch=%0d o=%h exp ch=3 o=44", c, o_ch, o); end
    end
    s_en = 1'b0;
    apply(32'h44332211, 4'hF, 1'b1);
    checks++;
    if (i_rdy !== 4'b0010) begin failures++; $display("FAIL ovr_resume_rdy got=%b exp=0010", i_rdy); end
    tick();
    checks++;
    if (o_ch !== 2'd1) begin failures++; $display("FAIL ovr_resume got ch=%0d exp=1", o_ch); end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
`ifdef MUX_N1_SEL_EN
      s_en = ($urandom_range(0, 3) == 0);
      s = SW'($urandom_range(0, N-1));
`endif
      apply($urandom, N'($urandom), ($urandom_range(0, 3) != 0));
      exp_rdy = ref_rdy();
      checks++;
      if (i_rdy !== exp_rdy) begin failures++; $display("FAIL rand_rdy[%0d] got=%b exp=%b", c, i_rdy, exp_rdy); end
      tick();
      checks++;
      if (o_vld !== m_vld || (m_vld && (o !== m_o || int'(o_ch) != m_ch))) begin
        failures++;
        $display("FAIL rand_out[%0d] got vld=%b o=%h ch=%0d exp vld=%b o=%h ch=%0d", c, o_vld, o, o_ch, m_vld, m_o, m_ch);
      end
    end
    rst = 1'b0;
`ifdef MUX_N1_SEL_EN
    s_en = 1'b0;
`endif
  endtask

  initial begin
    m_o = '0; m_ch = 0; m_vld = 1'b0; m_p = 0;
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_drain();
    test_mid_reset();
`ifdef MUX_N1_SEL_EN
    test_override();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end

endmodule
